// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative shift-subtract divider, one quotient bit per clock.
//                Produces quotient and remainder for signed (two's complement,
//                truncating) or unsigned operands with a start/busy/done
//                handshake. Results and flags hold until the next completion.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                i_start           - request, sampled only while idle
//                i_signed_op       - 1 = signed division, 0 = unsigned
//                i_dividend/i_divisor - operands, captured with i_start
//                o_busy            - high while an operation is in flight
//                o_done            - one-cycle completion pulse
//                o_quotient/o_remainder - registered results
//                o_dz/o_of/o_zf    - divide-by-zero, signed overflow, zero quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signed_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_dz,
    output logic             o_of,
    output logic             o_zf
);

    localparam int               c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dsr;      // divisor magnitude
    logic [WIDTH-1:0]   r_a_orig;   // raw dividend, returned as remainder on divide-by-zero
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dz_pend;
    logic               r_of_pend;

    logic               r_done;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remd;
    logic               r_dz;
    logic               r_of;
    logic               r_zf;

    // ---------------- operand capture ----------------
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_sa    = i_signed_op & i_dividend[WIDTH-1];
    assign w_sb    = i_signed_op & i_divisor[WIDTH-1];
    assign w_abs_a = w_sa ? (~i_dividend + 1'b1) : i_dividend;
    assign w_abs_b = w_sb ? (~i_divisor + 1'b1) : i_divisor;

    // ---------------- one restoring iteration ----------------
    // The shifted remainder is always below 2*divisor, so a WIDTH+1 bit
    // difference never wraps and its top bit is a valid "negative" flag.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;

    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dsr};
    assign w_ge       = ~w_trial[WIDTH];
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

    // ---------------- sign fix-up and special-case override ----------------
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    always_comb begin
        w_q_final = r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
        w_r_final = r_r_neg ? (~r_rem + 1'b1) : r_rem;
        if (r_dz_pend) begin
            w_q_final = '1;
            w_r_final = r_a_orig;
        end else if (r_of_pend) begin
            w_q_final = c_MOST_NEG;
            w_r_final = '0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (i_start) w_next_state = c_CALC;
            c_CALC:  if (r_cnt == '0) w_next_state = c_FIX;
            c_FIX:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = (r_state != c_IDLE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_a_orig  <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_of_pend <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_cnt     <= c_CNT_LOAD;
                        r_rem     <= '0;
                        r_dvd     <= w_abs_a;
                        r_dsr     <= w_abs_b;
                        r_a_orig  <= i_dividend;
                        r_q_neg   <= w_sa ^ w_sb;
                        r_r_neg   <= w_sa;
                        r_dz_pend <= (i_divisor == '0);
                        r_of_pend <= i_signed_op && (i_dividend == c_MOST_NEG) &&
                                     (i_divisor == '1);
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_quot <= '0;
            r_remd <= '0;
            r_dz   <= 1'b0;
            r_of   <= 1'b0;
            r_zf   <= 1'b0;
        end else begin
            r_done <= (r_state == c_FIX);
            if (r_state == c_FIX) begin
                r_quot <= w_q_final;
                r_remd <= w_r_final;
                r_dz   <= r_dz_pend;
                r_of   <= r_of_pend & ~r_dz_pend;
                r_zf   <= (w_q_final == '0);
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_remd;
    assign o_dz        = r_dz;
    assign o_of        = r_of;
    assign o_zf        = r_zf;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider: fixed vector table,
//                handshake/latency corner sequences and randomized operands
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_signed_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_dz;
    logic        o_of;
    logic        o_zf;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_signed_op (i_signed_op),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_dz        (o_dz),
        .o_of        (o_of),
        .o_zf        (o_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        of;
        logic        zf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input logic of, input logic zf);
        chk({name, ".q"}, o_quotient, q);
        chk({name, ".r"}, o_remainder, r);
        chk({name, ".flags"}, {29'd0, o_dz, o_of, o_zf}, {29'd0, dz, of, zf});
    endtask

    // Reference: plain integer division on 64-bit values.
    task automatic model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic of, output logic zf);
        longint sa, sb, tq, tr;
        dz = 1'b0;
        of = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            of = 1'b1;
        end else begin
            if (sg) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end
        zf = (q == 32'd0);
    endtask

    // Drive a request now (just after an edge); returns just after the start edge.
    task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
        i_start     = 1'b1;
        i_signed_op = sg;
        i_dividend  = a;
        i_divisor   = b;
        @(posedge clk);
        #1;
        i_start     = 1'b0;
        i_dividend  = $urandom;
        i_divisor   = $urandom;
        i_signed_op = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(inout int edges, inout int bc);
        while (!o_done && edges < 100) begin
            if (o_busy) bc++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            4:       return 32'h0000_FFFF & $urandom;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int edges, bc, dcnt;
        logic [31:0] eq, er;
        logic edz, eof, ezf, sg;
        logic [31:0] a, b;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,          1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0, 1'b0};

        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_signed_op = 1'b0;
        i_dividend  = 32'd0;
        i_divisor   = 32'd0;

        // ---- reset state ----
        #22;
        chk("reset.busy_done", {30'd0, o_busy, o_done}, 32'd0);
        chk_outs("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- vector table ----
        for (int i = 0; i < 9; i++) begin
            launch(tbl[i].sg, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d.busy_at_E0", i), {31'd0, o_busy}, 32'd1);
            edges = 0;
            bc    = 0;
            wait_done(edges, bc);
            chk($sformatf("tbl%0d.latency", i), edges, 33);
            chk($sformatf("tbl%0d.busy_cycles", i), bc, 33);
            chk_outs($sformatf("tbl%0d", i), tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].of, tbl[i].zf);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.done_drop", i), {31'd0, o_done}, 32'd0);
            chk_outs($sformatf("tbl%0d.hold", i), tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].of, tbl[i].zf);
        end

        // ---- start while busy is ignored ----
        launch(1'b0, 32'd5, 32'd9);
        edges = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            edges++;
        end
        i_start     = 1'b1;
        i_signed_op = 1'b1;
        i_dividend  = 32'd100;
        i_divisor   = 32'd3;
        @(posedge clk);
        #1;
        edges++;
        i_start = 1'b0;
        bc = 0;
        wait_done(edges, bc);
        chk("busy_start.latency", edges, 33);
        chk_outs("busy_start", 32'd0, 32'd5, 1'b0, 1'b0, 1'b1);

        // ---- back-to-back: start held in the done cycle ----
        @(posedge clk);
        #1;
        launch(1'b0, 32'd100, 32'd7);
        edges = 0;
        bc    = 0;
        wait_done(edges, bc);
        chk("b2b.first_latency", edges, 33);
        chk_outs("b2b.first", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 32'd50, 32'd5);
        chk("b2b.accepted", {30'd0, o_busy, o_done}, 32'd2);
        chk_outs("b2b.old_held", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        edges = 0;
        bc    = 0;
        wait_done(edges, bc);
        chk("b2b.second_latency", edges, 33);
        chk_outs("b2b.second", 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_done) dcnt++;
        end
        chk("b2b.no_extra_done", dcnt, 0);

        // ---- reset in the middle of an operation ----
        launch(1'b0, 32'd100, 32'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.busy_done", {30'd0, o_busy, o_done}, 32'd0);
        chk_outs("midrst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_done || o_busy) dcnt++;
        end
        #3;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_done || o_busy) dcnt++;
        end
        chk("midrst.quiet", dcnt, 0);
        launch(1'b0, 32'd9, 32'd3);
        edges = 0;
        bc    = 0;
        wait_done(edges, bc);
        chk("midrst.fresh_latency", edges, 33);
        chk_outs("midrst.fresh", 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

        // ---- randomized operands against the reference model ----
        for (int n = 0; n < 150; n++) begin
            sg = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            model(sg, a, b, eq, er, edz, eof, ezf);
            @(posedge clk);
            #1;
            launch(sg, a, b);
            edges = 0;
            bc    = 0;
            wait_done(edges, bc);
            chk($sformatf("rnd%0d.latency", n), edges, 33);
            chk_outs($sformatf("rnd%0d(%0d %08h/%08h)", n, sg, a, b), eq, er, edz, eof, ezf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
